// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : fifo_stream_reader
// Purpose  : Read-side drain engine for the AXI2SDRAM clock-crossing FIFO.
//            Pops the FIFO's registered read port (data valid one cycle after
//            the pop) and re-presents the words as a first-word-fall-through
//            valid/ready stream through a 2-entry buffer. This lets the stream
//            run at one word per cycle with no bubbles.
// Ports    : clk, reset       - consumer clock, synchronous active-high reset
//            fifo_empty       - FIFO empty flag (read-domain view)
//            fifo_rd_en       - pop request to the FIFO
//            fifo_data_out    - FIFO read data, valid the cycle after a pop
//            m_valid/m_ready  - stream handshake
//            m_data           - stream word (head of buffer)
//            flush            - discard all buffered and in-flight words
//            busy             - buffer non-empty or pop in flight
//            delivered_cnt    - words handed over        (RD_STATS_EN)
//            stall_cnt        - cycles valid & !ready    (RD_STATS_EN)
// Options  : define RD_STATS_EN to build the statistics counters; without it
//            the counter ports are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_stream_reader #(
  parameter int DATA_SIZE = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  input  logic [DATA_SIZE-1:0] fifo_data_out,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATA_SIZE-1:0] m_data,
  input  logic                 flush,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] delivered_cnt,
  output logic [CNT_WIDTH-1:0] stall_cnt
);

  logic [1:0]           occ;       // buffered words, 0..2
  logic                 inflight;  // pop issued last cycle, data arriving now
  logic                 drop;      // discard marker for a word caught by flush
  logic [DATA_SIZE-1:0] head;
  logic [DATA_SIZE-1:0] tail;

  logic                 pop_out;
  logic                 capture;
  logic [2:0]           level;
  logic [1:0]           wr_slot;

  assign pop_out = m_valid & m_ready;

  // Words already committed to the buffer once this cycle's pop leaves.
  // occ + inflight never exceeds 2, so level stays within 0..2.
  assign level = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop_out};

  assign fifo_rd_en = !reset && !flush && !fifo_empty && (level < 3'd2);

  // A word arriving during a flush cycle is part of what the flush discards.
  assign capture = inflight && !drop && !flush;

  // The arriving word lands behind whatever survives this cycle's pop.
  // When capture is set, occ - pop_out is 0 or 1.
  assign wr_slot = occ - {1'b0, pop_out};

  always_ff @(posedge clk) begin
    if (reset) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      drop     <= 1'b0;
      head     <= '0;
      tail     <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (flush) begin
        occ  <= 2'd0;
        drop <= inflight;
      end else begin
        // rd_en is blocked in the flush cycle, so the cycle after a flush has
        // no word arriving and the marker can be retired unconditionally.
        drop <= 1'b0;
        occ  <= occ + {1'b0, capture} - {1'b0, pop_out};
        if (pop_out) begin
          head <= tail;
        end
        // Placed after the shift so a capture into slot 0 takes priority.
        if (capture) begin
          if (wr_slot == 2'd0) begin
            head <= fifo_data_out;
          end else begin
            tail <= fifo_data_out;
          end
        end
      end
    end
  end

  assign m_valid = (occ != 2'd0);
  assign m_data  = head;
  assign busy    = (occ != 2'd0) || inflight;

`ifdef RD_STATS_EN
  logic [CNT_WIDTH-1:0] deliv_q;
  logic [CNT_WIDTH-1:0] stall_q;

  // Counters clear on reset only; a flush leaves the history intact.
  always_ff @(posedge clk) begin
    if (reset) begin
      deliv_q <= '0;
      stall_q <= '0;
    end else begin
      if (pop_out) begin
        deliv_q <= deliv_q + 1'b1;
      end
      if (m_valid && !m_ready) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

  assign delivered_cnt = deliv_q;
  assign stall_cnt     = stall_q;
`else
  assign delivered_cnt = '0;
  assign stall_cnt     = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_stream_reader
// Purpose  : Self-checking bench for fifo_stream_reader. A behavioural FIFO
//            feeds the DUT. A reference model tracks the words popped but not
//            yet delivered as a queue. Each entry becomes visible two cycles
//            after its pop. Flush and reset clear the queue. The model
//            predicts rd_en, m_valid, m_data, busy and the statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_stream_reader;

  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_data_out;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          flush;
  logic          busy;
  logic [CW-1:0] delivered_cnt;
  logic [CW-1:0] stall_cnt;

  fifo_stream_reader #(.DATA_SIZE(DW), .CNT_WIDTH(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .fifo_empty    (fifo_empty),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_data_out (fifo_data_out),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .flush         (flush),
    .busy          (busy),
    .delivered_cnt (delivered_cnt),
    .stall_cnt     (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    int            rdy;   // first cycle the word may be presented
  } ent_t;

  logic [DW-1:0] src[$];   // FIFO contents, in write order
  int            rptr;     // FIFO read pointer
  ent_t          q[$];     // popped, not yet delivered or discarded
  int            cyc;
  int            n_del;
  int            n_stall;
  int            n_words;
  bit            armed;
  bit            after_rst;
  int            total;
  int            bad;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [CW-1:0] cnt_exp(input int n);
`ifdef RD_STATS_EN
    return n[CW-1:0];
`else
    return '0;
`endif
  endfunction

  task automatic run_cycle(input logic r, input logic f, input logic rd, input logic blk);
    logic exp_valid;
    logic exp_rden;
    logic deliver;
    logic pop_now;
    ent_t e;
    @(negedge clk);
    reset      = r;
    flush      = f;
    m_ready    = rd;
    fifo_empty = blk || (rptr >= src.size());
    #1;
    exp_valid = (q.size() != 0) && (q[0].rdy <= cyc);
    deliver   = exp_valid && rd;
    exp_rden  = !r && !f && !fifo_empty && ((q.size() - int'(deliver)) < 2);
    if (armed) begin
      chk("rd_en", fifo_rd_en, exp_rden);
      chk("rd_en_while_empty", fifo_rd_en & fifo_empty, 1'b0);
      chk("m_valid", m_valid, exp_valid);
      chk("busy", busy, q.size() != 0);
      if (exp_valid) chk("m_data", m_data, q[0].d);
      if (after_rst) chk("m_data_after_reset", m_data, 0);
      chk("delivered_cnt", delivered_cnt, cnt_exp(n_del));
      chk("stall_cnt", stall_cnt, cnt_exp(n_stall));
    end
    if (r) begin
      q.delete();
      n_del   = 0;
      n_stall = 0;
    end else begin
      if (deliver) begin
        void'(q.pop_front());
        n_del++;
        n_words++;
      end
      if (exp_valid && !rd) n_stall++;
      if (f) begin
        q.delete();
      end else if (exp_rden) begin
        e.d   = src[rptr];
        e.rdy = cyc + 2;
        q.push_back(e);
      end
    end
    pop_now   = fifo_rd_en && (rptr < src.size());
    after_rst = r;
    @(posedge clk);
    #1;
    cyc++;
    armed = 1'b1;
    if (pop_now) begin
      fifo_data_out = src[rptr];
      rptr++;
    end else begin
      fifo_data_out = $urandom;
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((q.size() != 0 || rptr < src.size()) && n < 200) begin
      run_cycle(1'b0, 1'b0, 1'b1, 1'b0);
      n++;
    end
    chk(tag, (q.size() == 0 && rptr >= src.size()), 1'b1);
  endtask

  task automatic load4(input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] c, input logic [DW-1:0] d);
    src.push_back(a);
    src.push_back(b);
    src.push_back(c);
    src.push_back(d);
  endtask

  initial begin
    int start;
    reset = 1'b1; flush = 1'b0; m_ready = 1'b0; fifo_empty = 1'b1;
    fifo_data_out = '0;
    rptr = 0; cyc = 0; n_del = 0; n_stall = 0; n_words = 0;
    armed = 1'b0; after_rst = 1'b0; total = 0; bad = 0;

    // Reset with the FIFO empty, then one idle cycle showing the reset state.
    repeat (3) run_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_m_data", m_data, 0);

    // Preloaded stream, m_ready held high.
    load4(32'h11, 32'h22, 32'h33, 32'h44);
    repeat (10) run_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t1_delivered", delivered_cnt, cnt_exp(4));

    // Backpressure: two cycles before valid, then five stalled cycles.
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    load4(32'h11, 32'h22, 32'h33, 32'h44);
    repeat (7) run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_hold_m_data", m_data, 32'h11);
    repeat (8) run_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t2_stall", stall_cnt, cnt_exp(5));
    chk("t2_delivered", delivered_cnt, cnt_exp(4));
    chk("t2_no_stats_deliv_zero_or_four", delivered_cnt, cnt_exp(n_del));

    // Reset in the middle of a stream with the buffer full.
    load4(32'h55, 32'h66, 32'h77, 32'h88);
    repeat (4) run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_full_valid", m_valid, 1'b1);
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3_after_reset_valid", m_valid, 1'b0);
    drain("t3_drain");

    // Flush the cycle after a pop with one word buffered.
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    load4(32'hA1, 32'hA2, 32'hA3, 32'hA4);
    repeat (2) run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    run_cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("t4_flush_valid", m_valid, 1'b0);
    drain("t4_drain");

    // 1000 random words, empty flag toggling every cycle, random m_ready.
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 1000; i++) src.push_back($urandom);
    start = n_words;
    for (int i = 0; i < 20000 && (q.size() != 0 || rptr < src.size()); i++) begin
      run_cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'(cyc % 2));
    end
    chk("t5_word_count", n_words - start, 1000);

    // Random flushes mixed with random backpressure and empty gaps.
    for (int i = 0; i < 300; i++) src.push_back($urandom);
    for (int i = 0; i < 400; i++) begin
      run_cycle(1'b0, 1'($urandom_range(0, 15) == 0),
                1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) == 0));
    end
    drain("t6_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
